// File: rtl/memory_game_pkg.sv
// Shared types and helpers for the Simon-style memory game engine.
package memory_game_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    APPEND   = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_GAP = 3'd3,
    WAIT_IN  = 3'd4,
    WIN      = 3'd5,
    LOSE     = 3'd6
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // One right shift of the Galois LFSR; the mask is folded in when a one falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/memory_game_lfsr.sv
// Free-running 16-bit Galois LFSR used as the symbol source.
module memory_game_lfsr
  import memory_game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  // Advance every cycle regardless of game state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/memory_game_engine.sv
// Memory game core: grows a random sequence, replays it, and checks player presses.
module memory_game_engine
  import memory_game_pkg::*;
#(
  parameter int          NUM_BUTTONS    = 4,
  parameter int          MAX_LEVEL      = 16,
  parameter int          SHOW_CYCLES    = 8,
  parameter int          GAP_CYCLES     = 2,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [15:0] SEED           = 16'hACE1,
  localparam int         BW             = $clog2(NUM_BUTTONS),
  localparam int         LW             = $clog2(MAX_LEVEL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          btn_valid,
  input  logic [BW-1:0] btn_id,
  output logic          show_valid,
  output logic [BW-1:0] show_id,
  output logic [LW-1:0] level,
  output logic          win,
  output logic          lose,
  output logic [2:0]    state_o
);

  // Sequence store is rounded up to a power of two so idx/level slices index it cleanly.
  localparam int AW    = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  localparam int DEPTH = 1 << AW;
  localparam int T_A   = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int T_MAX = (TIMEOUT_CYCLES > T_A) ? TIMEOUT_CYCLES : T_A;
  localparam int TW    = $clog2(T_MAX + 1);

  state_t          state;
  state_t          state_next;
  logic [LW-1:0]   level_next;
  logic [LW-1:0]   idx;
  logic [LW-1:0]   idx_next;
  logic [TW-1:0]   tmr;
  logic [TW-1:0]   tmr_next;
  logic [BW-1:0]   seq [DEPTH];
  logic            seq_we;
  logic [15:0]     lfsr_q;
  logic [BW-1:0]   symbol;
  logic [BW-1:0]   cur_sym;
  logic            at_last;
  logic            unused_lfsr_bits;

  memory_game_lfsr #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign symbol           = lfsr_q[BW-1:0];
  assign unused_lfsr_bits = ^lfsr_q[15:BW];
  assign cur_sym          = seq[idx[AW-1:0]];
  assign at_last          = (idx == (level - LW'(1)));

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      level <= '0;
      idx   <= '0;
      tmr   <= '0;
    end else begin
      state <= state_next;
      level <= level_next;
      idx   <= idx_next;
      tmr   <= tmr_next;
    end
  end

  // Sequence storage; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (seq_we) begin
      seq[level[AW-1:0]] <= symbol;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_next = state;
    level_next = level;
    idx_next   = idx;
    tmr_next   = tmr;
    seq_we     = 1'b0;
    case (state)
      IDLE, WIN, LOSE: begin
        if (start) begin
          level_next = '0;
          state_next = APPEND;
        end else begin
          state_next = state;
        end
      end
      APPEND: begin
        seq_we     = 1'b1;
        level_next = level + LW'(1);
        idx_next   = '0;
        tmr_next   = '0;
        state_next = SHOW_ON;
      end
      SHOW_ON: begin
        if (tmr == TW'(SHOW_CYCLES - 1)) begin
          tmr_next   = '0;
          state_next = SHOW_GAP;
        end else begin
          tmr_next = tmr + TW'(1);
        end
      end
      SHOW_GAP: begin
        if (tmr == TW'(GAP_CYCLES - 1)) begin
          tmr_next = '0;
          if (at_last) begin
            idx_next   = '0;
            state_next = WAIT_IN;
          end else begin
            idx_next   = idx + LW'(1);
            state_next = SHOW_ON;
          end
        end else begin
          tmr_next = tmr + TW'(1);
        end
      end
      WAIT_IN: begin
        // A press on the timeout cycle takes priority over the timeout.
        if (btn_valid) begin
          if (btn_id != cur_sym) begin
            state_next = LOSE;
          end else if (at_last) begin
            state_next = (level == LW'(MAX_LEVEL)) ? WIN : APPEND;
          end else begin
            idx_next = idx + LW'(1);
            tmr_next = '0;
          end
        end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
          state_next = LOSE;
        end else begin
          tmr_next = tmr + TW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore output decode.
  always_comb begin
    show_valid = (state == SHOW_ON);
    show_id    = show_valid ? cur_sym : '0;
    win        = (state == WIN);
    lose       = (state == LOSE);
    state_o    = state;
  end

endmodule

// File: tb/tb_memory_game_engine.sv
// Randomized self-checking bench for memory_game_engine with a behavioural game model.
module tb_memory_game_engine;

  localparam int NB   = 4;
  localparam int BW   = 2;
  localparam int MAXL = 4;
  localparam int LW   = 3;
  localparam int SHOW = 8;
  localparam int GAP  = 2;
  localparam int TO   = 64;

  localparam int S_IDLE   = 0;
  localparam int S_APPEND = 1;
  localparam int S_WAIT   = 4;
  localparam int S_WIN    = 5;
  localparam int S_LOSE   = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          btn_valid;
  logic [BW-1:0] btn_id;
  logic          show_valid;
  logic [BW-1:0] show_id;
  logic [LW-1:0] level;
  logic          win;
  logic          lose;
  logic [2:0]    state_o;

  memory_game_engine #(
    .NUM_BUTTONS(NB), .MAX_LEVEL(MAXL), .SHOW_CYCLES(SHOW),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn_valid(btn_valid), .btn_id(btn_id),
    .show_valid(show_valid), .show_id(show_id), .level(level),
    .win(win), .lose(lose), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference random source: right shift, XOR in the mask whenever the dropped bit is one.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    return (x >> 1) ^ ((x % 2 == 1) ? 16'hB400 : 16'h0000);
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_adv(m_lfsr);
  end

  int exp_seq[$];
  int n_checks = 0;
  int n_pass   = 0;
  int sym0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_show_valid"}, show_valid, 0);
    check({tag, "_show_id"}, show_id, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_win"}, win, 0);
    check({tag, "_lose"}, lose, 0);
    check({tag, "_state"}, state_o, S_IDLE);
  endtask

  // Fixed-length reset sequence so the seeded symbol timeline is repeatable.
  task automatic reset_and_probe;
    rst = 1'b1; start = 1'b0; btn_valid = 1'b0; btn_id = '0;
    tick; tick;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    check_reset_outputs("rst_rel");
    btn_valid = 1'b1; btn_id = 2'd1;
    tick;
    btn_valid = 1'b0;
    check("idle_btn_state", state_o, S_IDLE);
    check("idle_btn_level", level, 0);
  endtask

  // Leaves the bench in the APPEND cycle with the new symbol recorded.
  task automatic start_game;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("start_append", state_o, S_APPEND);
    check("start_win", win, 0);
    check("start_lose", lose, 0);
    exp_seq.delete();
    exp_seq.push_back(int'(m_lfsr % NB));
  endtask

  // From the APPEND cycle: watch the whole replay, end in the first WAIT_IN cycle.
  task automatic replay(input bit poke);
    int n = exp_seq.size();
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < SHOW; c++) begin
        tick;
        btn_valid = 1'b0;
        check("show_valid_on", show_valid, 1);
        check("show_id", show_id, exp_seq[i]);
        if (poke && c == 3) begin
          btn_valid = 1'b1;
          btn_id = BW'($urandom_range(0, NB - 1));
        end
      end
      for (int g = 0; g < GAP; g++) begin
        tick;
        btn_valid = 1'b0;
        check("gap_dark", show_valid, 0);
        check("gap_id", show_id, 0);
      end
    end
    tick;
    check("wait_state", state_o, S_WAIT);
    check("wait_level", level, n);
  endtask

  // Enter the current round's presses with random idle gaps; one may be wrong.
  task automatic press_round(input int wrong_at);
    int n = exp_seq.size();
    for (int i = 0; i < n; i++) begin
      int d = $urandom_range(0, 12);
      repeat (d) tick;
      check("pre_press_wait", state_o, S_WAIT);
      btn_valid = 1'b1;
      btn_id = BW'((i == wrong_at) ? (exp_seq[i] + 1) % NB : exp_seq[i]);
      tick;
      btn_valid = 1'b0;
      if (i == wrong_at) begin
        check("wrong_lose", lose, 1);
        check("wrong_state", state_o, S_LOSE);
        check("wrong_level", level, n);
        return;
      end else if (i < n - 1) begin
        check("mid_press_wait", state_o, S_WAIT);
      end else if (n == MAXL) begin
        check("final_win", win, 1);
        check("final_state", state_o, S_WIN);
        check("final_level", level, n);
      end else begin
        check("next_append", state_o, S_APPEND);
        check("next_level", level, n);
        exp_seq.push_back(int'(m_lfsr % NB));
      end
    end
  endtask

  initial begin
    reset_and_probe;

    start_game;
    sym0 = exp_seq[0];
    replay(1'b0);
    press_round(-1);
    replay(1'b0);
    press_round(1);

    start_game;
    replay(1'b0);
    for (int k = 0; k < TO; k++) begin
      check("timeout_wait", state_o, S_WAIT);
      check("timeout_early", lose, 0);
      tick;
    end
    check("timeout_lose", lose, 1);
    check("timeout_state", state_o, S_LOSE);

    start_game;
    replay(1'b0);
    repeat (TO - 1) tick;
    check("late_wait", state_o, S_WAIT);
    btn_valid = 1'b1;
    btn_id = BW'(exp_seq[0]);
    tick;
    btn_valid = 1'b0;
    check("late_press_append", state_o, S_APPEND);
    exp_seq.push_back(int'(m_lfsr % NB));
    replay(1'b1);
    press_round(-1);
    replay(1'b0);
    press_round(-1);
    replay(1'b0);
    press_round(-1);

    start_game;
    replay(1'b0);
    press_round(-1);
    replay(1'b0);
    press_round(-1);
    repeat (3) tick;
    check("mid_show_on", show_valid, 1);
    rst = 1'b1;
    tick;
    check_reset_outputs("mid_rst");
    reset_and_probe;
    start_game;
    exp_seq[0] = sym0;
    replay(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
